rf_writeback_queue: RTL and testbench

//  Write-side driver for the 32x32 register file's write port (Awr/Din/WrEn).

---
 rtl/rf_writeback_queue_if.sv | 53 +++++
 rtl/rf_writeback_queue.sv | 111 +++++++++++
 tb/tb_rf_writeback_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_queue_if.sv
// Writeback queue bus: MEM/ALU request channels, regfile write port and
// queue status. Optional forwarding lookup ports exist only when
// RFWB_FWD_EN is defined.
interface rf_writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          MemValid;
  logic          MemReady;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemData;
  logic          AluValid;
  logic          AluReady;
  logic [AW-1:0] AluAddr;
  logic [DW-1:0] AluData;
  logic [AW-1:0] Awr;
  logic [DW-1:0] Din;
  logic          WrEn;
  logic [CW-1:0] Count;
  logic          Full;
  logic          Empty;
`ifdef RFWB_FWD_EN
  logic [AW-1:0] Ard1;
  logic [AW-1:0] Ard2;
  logic          Hit1;
  logic          Hit2;
  logic [DW-1:0] Fwd1;
  logic [DW-1:0] Fwd2;
`endif

  // Requester / observer side
  modport master (
    output MemValid, MemAddr, MemData, AluValid, AluAddr, AluData,
`ifdef RFWB_FWD_EN
    output Ard1, Ard2,
    input  Hit1, Hit2, Fwd1, Fwd2,
`endif
    input  MemReady, AluReady, Awr, Din, WrEn, Count, Full, Empty
  );

  // Queue side
  modport slave (
    input  MemValid, MemAddr, MemData, AluValid, AluAddr, AluData,
`ifdef RFWB_FWD_EN
    input  Ard1, Ard2,
    output Hit1, Hit2, Fwd1, Fwd2,
`endif
    output MemReady, AluReady, Awr, Din, WrEn, Count, Full, Empty
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// Writeback queue feeding the regfile write port. MEM and ALU results are
// buffered in a DEPTH-entry FIFO (MEM ahead of ALU when both arrive) and the
// head retires one entry per cycle. r0 writes are acknowledged but dropped.
// Optional macro RFWB_FWD_EN adds a combinational two-port forwarding lookup
// over the queued entries.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic              Clk,
  input logic              Rstn,
  rf_writeback_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      wp_q, wp_d;
  logic [PW-1:0]      rp_q, rp_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic          empty;
  logic          pop;
  logic [CW:0]   free_slots;
  logic [CW:0]   alu_need;
  logic          mem_ready;
  logic          alu_ready;
  logic          mem_push;
  logic          alu_push;

  assign empty = (cnt_q == '0);
  assign pop   = ~empty;

  // Free slots count the head leaving this cycle, so a full queue still
  // takes one request per cycle. Readies depend on Count and MemValid only.
  always_comb begin
    free_slots = (CW+1)'(DEPTH) - {1'b0, cnt_q} + {{CW{1'b0}}, pop};
    alu_need   = {{CW{1'b0}}, 1'b1} + {{CW{1'b0}}, bus.MemValid};
    mem_ready  = (free_slots >= (CW+1)'(1));
    alu_ready  = (free_slots >= alu_need);
    mem_push   = bus.MemValid & mem_ready & (bus.MemAddr != '0);
    alu_push   = bus.AluValid & alu_ready & (bus.AluAddr != '0);
  end

  // Next-state: MEM lands at wp, ALU behind it; head advances on every write.
  always_comb begin
    mem_d = mem_q;
    if (mem_push) mem_d[wp_q] = '{addr: bus.MemAddr, data: bus.MemData};
    if (alu_push) mem_d[wp_q + PW'(mem_push)] = '{addr: bus.AluAddr, data: bus.AluData};
    wp_d  = wp_q + PW'(mem_push) + PW'(alu_push);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  // Queue state; reset discards every pending entry.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.MemReady = mem_ready;
  assign bus.AluReady = alu_ready;
  assign bus.WrEn     = pop;
  assign bus.Awr      = empty ? '0 : mem_q[rp_q].addr;
  assign bus.Din      = empty ? '0 : mem_q[rp_q].data;
  assign bus.Count    = cnt_q;
  assign bus.Full     = (cnt_q == CW'(DEPTH));
  assign bus.Empty    = empty;

`ifdef RFWB_FWD_EN
  logic [PW-1:0] fidx;

  // Walk oldest to youngest so the last match (youngest) wins; the head is
  // included, this cycle's incoming requests are not.
  always_comb begin
    bus.Hit1 = 1'b0;
    bus.Hit2 = 1'b0;
    bus.Fwd1 = '0;
    bus.Fwd2 = '0;
    fidx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = rp_q + PW'(i);
      if (CW'(i) < cnt_q) begin
        if ((bus.Ard1 != '0) && (mem_q[fidx].addr == bus.Ard1)) begin
          bus.Hit1 = 1'b1;
          bus.Fwd1 = mem_q[fidx].data;
        end
        if ((bus.Ard2 != '0) && (mem_q[fidx].addr == bus.Ard2)) begin
          bus.Hit2 = 1'b1;
          bus.Fwd2 = mem_q[fidx].data;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue (DEPTH=4). Inputs change on the
// falling edge; outputs are sampled on the falling edge (+1 for readies).
module tb_rf_writeback_queue;
  logic Clk;
  logic Rstn;
  int   total;
  int   bad;

  rf_writeback_queue_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

  rf_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .Clk  (Clk),
    .Rstn (Rstn),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    bus.MemValid = mv; bus.MemAddr = ma; bus.MemData = md;
    bus.AluValid = av; bus.AluAddr = aa; bus.AluData = ad;
  endtask

  task automatic test_reset;
    Rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      #1;
      total++; if (bus.WrEn !== 1'b0) begin bad++; $display("FAIL rst_wren got=%0h exp=0", bus.WrEn); end
      total++; if (bus.Awr !== 5'd0) begin bad++; $display("FAIL rst_awr got=%0h exp=0", bus.Awr); end
      total++; if (bus.Din !== 32'd0) begin bad++; $display("FAIL rst_din got=%0h exp=0", bus.Din); end
      total++; if (bus.Count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.Count); end
      total++; if (bus.Empty !== 1'b1 || bus.Full !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b%0b exp=10", bus.Empty, bus.Full); end
      total++; if (bus.MemReady !== 1'b1 || bus.AluReady !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b%0b exp=11", bus.MemReady, bus.AluReady); end
    end
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0);
    Rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      total++; if (bus.WrEn !== 1'b0) begin bad++; $display("FAIL idle_wren cyc=%0d got=%0h exp=0", i, bus.WrEn); end
    end
  endtask

  task automatic test_single;
    @(negedge Clk);
    drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    #1;
    total++; if (bus.AluReady !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b exp=1", bus.AluReady); end
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.WrEn !== 1'b1) begin bad++; $display("FAIL single_wren got=%0b exp=1", bus.WrEn); end
    total++; if (bus.Awr !== 5'd5) begin bad++; $display("FAIL single_awr got=%0d exp=5", bus.Awr); end
    total++; if (bus.Din !== 32'hDEADBEEF) begin bad++; $display("FAIL single_din got=%0h exp=deadbeef", bus.Din); end
    @(negedge Clk);
    total++; if (bus.WrEn !== 1'b0 || bus.Empty !== 1'b1) begin bad++; $display("FAIL single_done wren=%0b empty=%0b exp=0,1", bus.WrEn, bus.Empty); end
    total++; if (bus.Awr !== 5'd0 || bus.Din !== 32'd0) begin bad++; $display("FAIL single_zero awr=%0h din=%0h exp=0,0", bus.Awr, bus.Din); end
  endtask

  task automatic test_dual;
    @(negedge Clk);
    drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    #1;
    total++; if (bus.MemReady !== 1'b1 || bus.AluReady !== 1'b1) begin bad++; $display("FAIL dual_ready got=%0b%0b exp=11", bus.MemReady, bus.AluReady); end
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.Count !== 3'd2) begin bad++; $display("FAIL dual_count got=%0d exp=2", bus.Count); end
    total++; if (bus.WrEn !== 1'b1 || bus.Awr !== 5'd3 || bus.Din !== 32'h11) begin bad++; $display("FAIL dual_first wren=%0b awr=%0d din=%0h exp=1,3,11", bus.WrEn, bus.Awr, bus.Din); end
    @(negedge Clk);
    total++; if (bus.WrEn !== 1'b1 || bus.Awr !== 5'd4 || bus.Din !== 32'h22) begin bad++; $display("FAIL dual_second wren=%0b awr=%0d din=%0h exp=1,4,22", bus.WrEn, bus.Awr, bus.Din); end
    @(negedge Clk);
    total++; if (bus.WrEn !== 1'b0) begin bad++; $display("FAIL dual_done got=%0b exp=0", bus.WrEn); end
  endtask

  // Entry k (1-based) carries addr k and data k<<8; eight offered, seven accepted.
  task automatic test_full;
    logic [2:0] exp_cnt;
    @(negedge Clk);
    drive(1, 5'd1, 32'h100, 1, 5'd2, 32'h200);
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk);
      total++; if (bus.WrEn !== 1'b1 || bus.Awr !== 5'(k + 1) || bus.Din !== 32'((k + 1) << 8))
        begin bad++; $display("FAIL full_order k=%0d wren=%0b awr=%0d din=%0h exp=1,%0d,%0h", k, bus.WrEn, bus.Awr, bus.Din, k + 1, (k + 1) << 8); end
      if (k < 4) begin
        exp_cnt = (k == 0) ? 3'd2 : (k == 1) ? 3'd3 : 3'd4;
        total++; if (bus.Count !== exp_cnt) begin bad++; $display("FAIL full_count k=%0d got=%0d exp=%0d", k, bus.Count, exp_cnt); end
      end
      case (k)
        0: drive(1, 5'd3, 32'h300, 1, 5'd4, 32'h400);
        1: drive(1, 5'd5, 32'h500, 1, 5'd6, 32'h600);
        2: begin
          total++; if (bus.Full !== 1'b1) begin bad++; $display("FAIL full_flag got=%0b exp=1", bus.Full); end
          drive(1, 5'd7, 32'h700, 1, 5'd8, 32'h800);
          #1;
          total++; if (bus.MemReady !== 1'b1 || bus.AluReady !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b%0b exp=10", bus.MemReady, bus.AluReady); end
        end
        default: drive(0, 0, 0, 0, 0, 0);
      endcase
    end
    @(negedge Clk);
    total++; if (bus.Empty !== 1'b1 || bus.WrEn !== 1'b0) begin bad++; $display("FAIL full_drain empty=%0b wren=%0b exp=1,0", bus.Empty, bus.WrEn); end
  endtask

  task automatic test_r0;
    @(negedge Clk);
    drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    #1;
    total++; if (bus.AluReady !== 1'b1) begin bad++; $display("FAIL r0_ready got=%0b exp=1", bus.AluReady); end
    @(negedge Clk);
    total++; if (bus.Count !== 3'd0 || bus.WrEn !== 1'b0) begin bad++; $display("FAIL r0_drop count=%0d wren=%0b exp=0,0", bus.Count, bus.WrEn); end
    drive(1, 5'd0, 32'h55, 1, 5'd9, 32'h99);
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.Count !== 3'd1) begin bad++; $display("FAIL r0_mix_count got=%0d exp=1", bus.Count); end
    total++; if (bus.Awr !== 5'd9 || bus.Din !== 32'h99) begin bad++; $display("FAIL r0_mix_head awr=%0d din=%0h exp=9,99", bus.Awr, bus.Din); end
    @(negedge Clk);
    total++; if (bus.WrEn !== 1'b0) begin bad++; $display("FAIL r0_mix_done got=%0b exp=0", bus.WrEn); end
  endtask

  task automatic test_reset_mid;
    @(negedge Clk);
    drive(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    @(negedge Clk);
    drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.Count !== 3'd3) begin bad++; $display("FAIL mid_count got=%0d exp=3", bus.Count); end
    Rstn = 1'b0;
    #1;
    total++; if (bus.Count !== 3'd0 || bus.WrEn !== 1'b0) begin bad++; $display("FAIL mid_clear count=%0d wren=%0b exp=0,0", bus.Count, bus.WrEn); end
    @(negedge Clk);
    Rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      total++; if (bus.WrEn !== 1'b0) begin bad++; $display("FAIL mid_quiet cyc=%0d got=%0b exp=0", i, bus.WrEn); end
    end
  endtask

`ifdef RFWB_FWD_EN
  task automatic test_fwd;
    @(negedge Clk);
    bus.Ard1 = 5'd7;
    bus.Ard2 = 5'd0;
    drive(1, 5'd7, 32'hA, 1, 5'd7, 32'hB);
    #1;
    total++; if (bus.Hit1 !== 1'b0) begin bad++; $display("FAIL fwd_incoming got=%0b exp=0", bus.Hit1); end
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.Hit1 !== 1'b1 || bus.Fwd1 !== 32'hB) begin bad++; $display("FAIL fwd_young hit=%0b fwd=%0h exp=1,b", bus.Hit1, bus.Fwd1); end
    total++; if (bus.Hit2 !== 1'b0 || bus.Fwd2 !== 32'd0) begin bad++; $display("FAIL fwd_r0 hit=%0b fwd=%0h exp=0,0", bus.Hit2, bus.Fwd2); end
    @(negedge Clk);
    total++; if (bus.Hit1 !== 1'b1 || bus.Fwd1 !== 32'hB) begin bad++; $display("FAIL fwd_head hit=%0b fwd=%0h exp=1,b", bus.Hit1, bus.Fwd1); end
    @(negedge Clk);
    total++; if (bus.Hit1 !== 1'b0 || bus.Fwd1 !== 32'd0) begin bad++; $display("FAIL fwd_retired hit=%0b fwd=%0h exp=0,0", bus.Hit1, bus.Fwd1); end
    bus.Ard1 = 5'd0;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    Rstn  = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
`ifdef RFWB_FWD_EN
    bus.Ard1 = 5'd0;
    bus.Ard2 = 5'd0;
`endif
    test_reset;
    test_single;
    test_dual;
    test_full;
    test_r0;
`ifdef RFWB_FWD_EN
    test_fwd;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
